rgb_frame_packer: RTL and testbench
===================================

Name: rgb_frame_packer

Overview:
- Sits directly downstream of the Bayer demosaic stage.
- Consumes its per-pixel RGB332 byte stream (pixel byte, pixel address, write strobe) plus the sensor frame-valid.
- Packs four pixels per 32-bit word and writes words into a dual-port frame RAM split into two ping-pong banks.
- Exposes the most recently completed bank to the readout (SPI/host) side. A bank is never overwritten while it is locked for readout.

Parameters:
- PIXELS, 160000, expected pixels per frame (400x400 crop); used for the frame completeness check.
- WORD_AW, 16, word address width within one bank (ceil(PIXELS/4) must fit).

Ports:
- clk  in  1  system clock, same domain as demosaic stage
- reset  in  1  synchronous, active-high reset
- pixel_data  in  8  RGB332 pixel byte
- pixel_address  in  18  pixel index within the crop window
- pixel_wr_en  in  1  pixel_data/pixel_address valid this cycle
- fv  in  1  sensor frame valid
- capture_enable  in  1  sampled at fv rise; 0 = discard the next frame
- read_lock  in  1  host is reading; blocks bank swap
- rd_addr  in  WORD_AW  host word address within the read bank
- mem_wr_en  out  1  RAM write strobe
- mem_wr_addr  out  WORD_AW+1  {write_bank, word index}
- mem_wr_data  out  32  packed word, lane n = bits [8n+7:8n]
- mem_rd_addr  out  WORD_AW+1  {read_bank, rd_addr}, combinational
- read_bank  out  1  bank holding the last completed frame
- frame_ready  out  1  one-cycle pulse on bank swap
- frame_pixel_count  out  18  pixels accepted in the last finished frame
- frame_error  out  1  last finished frame count != PIXELS; sticky until next finished frame
- busy  out  1  state is CAPTURE or FLUSH

Behaviour:
- Reset values: mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, read_bank=0, write bank=1, frame_ready=0, frame_pixel_count=0, frame_error=0, busy=0, lane mask=0, state=SYNC.
- Reset mid-frame discards the partial frame. No RAM write is issued on the reset cycle.
- States and transitions:
  - SYNC: wait for fv=0, then go to IDLE. This prevents capturing a frame already in progress after reset.
  - IDLE: on fv rising edge (fv=1, previous fv=0), go to CAPTURE if capture_enable=1, else SKIP.
  - SKIP: ignore pixels; on fv falling edge go to IDLE.
  - CAPTURE: accept pixels; on fv falling edge go to FLUSH.
  - FLUSH: lasts exactly one cycle, then DONE.
  - DONE: lasts exactly one cycle, then IDLE.
- Packing (CAPTURE only):
  - Lane = pixel_address[1:0]; word index = pixel_address[17:2].
  - Each accepted pixel is stored in its lane of the pending word and sets the lane's mask bit.
  - The pixel counter increments by 1 per accepted pixel, saturating at 2^18-1.
- Word write:
  - Trigger: when the accepted pixel is in lane 3, the pending word (including that pixel) is written. mem_wr_en=1 on the next cycle (latency 1), the mask clears, and the next word starts empty.
  - Discontinuity: if an accepted pixel's word index differs from the pending word's index and the mask is non-zero, the pending word is written first (unfilled lanes = 0x00). The new pixel then opens a fresh word.
  - A discontinuity that also lands in lane 3 produces two consecutive write cycles. The second write is held in a one-entry skid register. At most one extra cycle.
  - mem_wr_en is high for exactly one cycle per word.
- FLUSH: if the mask is non-zero, write the partial word with unfilled lanes zero. Otherwise no write. The mask is cleared either way.
- DONE:
  - Latch frame_pixel_count.
  - Set frame_error = (count != PIXELS).
  - If read_lock=0: swap read_bank and write bank, and pulse frame_ready.
  - If read_lock=1: no swap and no pulse. The next frame overwrites the same write bank; the read bank is untouched.
  - Reset the pixel counter to 0.
- Input gating: pixel_wr_en outside CAPTURE is ignored.
- Event priority on the fv-falling cycle in CAPTURE:
  - A pixel with pixel_wr_en=1 on that cycle is still accepted.
  - An fv rising edge during FLUSH or DONE is not honoured; that frame is skipped (state returns to IDLE with fv high, waits for the next rise).
- read_lock changes take effect only in DONE. read_bank never changes while read_lock=1.
- mem_rd_addr tracks rd_addr and read_bank combinationally. RAM read latency belongs to the RAM, not this block.

Test Plan:
- Reset, capture_enable=1, one frame with addresses 0..159999 sequential, pixel_data = address[7:0] -> 40000 writes; word 0 = 0x03020100 at mem_wr_addr 0x10000 (bank 1); DONE: read_bank=1, frame_ready pulse, frame_pixel_count=160000, frame_error=0.
- Frame of 6 pixels (addresses 0..5) -> write of word 0 = 0x03020100, then FLUSH writes word 1 = 0x00000504; frame_pixel_count=6, frame_error=1.
- Two frames with read_lock=1 throughout -> both written to bank 1, read_bank stays 0, no frame_ready. Release lock, third frame -> swap, read_bank=1.
- capture_enable=0 at fv rise -> zero RAM writes, no frame_ready, counters unchanged. Re-enable -> next frame captured normally.
- Address jump 0,1,7 (lane 3 of word 1) -> writes 0x00000100 @ word 0 then 0xXX000000 @ word 1 on consecutive cycles.
- Assert reset mid-frame with fv=1, release while fv=1 -> no writes until fv falls and rises again; read_bank=0.

Source files
------------

// File: rtl/rgb_frame_packer.sv
// Packs RGB332 pixels four per 32-bit word into ping-pong frame RAM banks and hands the last finished bank to readout.
// Word write lands 1 cycle after its closing pixel (one extra skid cycle on a lane-3 discontinuity); inputs are never stalled.
module rgb_frame_packer #(
   parameter int PIXELS  = 160000,
   parameter int WORD_AW = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         pixel_data,
   input  logic [17:0]        pixel_address,
   input  logic               pixel_wr_en,
   input  logic               fv,
   input  logic               capture_enable,
   input  logic               read_lock,
   input  logic [WORD_AW-1:0] rd_addr,
   output logic               mem_wr_en,
   output logic [WORD_AW:0]   mem_wr_addr,
   output logic [31:0]        mem_wr_data,
   output logic [WORD_AW:0]   mem_rd_addr,
   output logic               read_bank,
   output logic               frame_ready,
   output logic [17:0]        frame_pixel_count,
   output logic               frame_error,
   output logic               busy
);

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_IDLE,
      ST_SKIP,
      ST_CAPTURE,
      ST_FLUSH,
      ST_DONE
   } state_t;

   localparam logic [17:0] PIXELS_C = 18'(PIXELS);

   state_t             state_q, state_d;
   logic               fv_prev_q, fv_prev_d;
   logic [31:0]        word_q, word_d;
   logic [WORD_AW-1:0] idx_q, idx_d;
   logic [3:0]         mask_q, mask_d;
   logic [17:0]        pix_cnt_q, pix_cnt_d;
   logic               wr_en_q, wr_en_d;
   logic [WORD_AW:0]   wr_addr_q, wr_addr_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic               skid_vld_q, skid_vld_d;
   logic [WORD_AW:0]   skid_addr_q, skid_addr_d;
   logic [31:0]        skid_data_q, skid_data_d;
   logic               read_bank_q, read_bank_d;
   logic               write_bank_q, write_bank_d;
   logic               frame_ready_q, frame_ready_d;
   logic [17:0]        frame_pixel_count_q, frame_pixel_count_d;
   logic               frame_error_q, frame_error_d;
   logic               busy_q, busy_d;

   logic               fv_rise, fv_fall, accept, disc;
   logic [1:0]         lane;
   logic [WORD_AW-1:0] pix_idx;
   logic [31:0]        base_word, merged;
   logic [3:0]         base_mask;
   logic               req_a_vld, req_b_vld;
   logic [WORD_AW:0]   req_a_addr, req_b_addr;
   logic [31:0]        req_a_data, req_b_data;

   // Incoming pixel merged into the pending word; a word-index change restarts from an empty word.
   always_comb begin
      lane      = pixel_address[1:0];
      pix_idx   = pixel_address[WORD_AW+1:2];
      accept    = (state_q == ST_CAPTURE) && pixel_wr_en;
      fv_rise   = fv && !fv_prev_q;
      fv_fall   = !fv && fv_prev_q;
      disc      = (mask_q != 4'd0) && (pix_idx != idx_q);
      base_word = (disc || (mask_q == 4'd0)) ? 32'd0 : word_q;
      base_mask = disc ? 4'd0 : mask_q;
      merged    = base_word;
      merged[{lane, 3'b000} +: 8] = pixel_data;
   end

   always_comb begin
      state_d             = state_q;
      fv_prev_d           = fv;
      word_d              = word_q;
      idx_d               = idx_q;
      mask_d              = mask_q;
      pix_cnt_d           = pix_cnt_q;
      wr_en_d             = 1'b0;
      wr_addr_d           = wr_addr_q;
      wr_data_d           = wr_data_q;
      skid_vld_d          = skid_vld_q;
      skid_addr_d         = skid_addr_q;
      skid_data_d         = skid_data_q;
      read_bank_d         = read_bank_q;
      write_bank_d        = write_bank_q;
      frame_ready_d       = 1'b0;
      frame_pixel_count_d = frame_pixel_count_q;
      frame_error_d       = frame_error_q;
      req_a_vld           = 1'b0;
      req_a_addr          = '0;
      req_a_data          = '0;
      req_b_vld           = 1'b0;
      req_b_addr          = '0;
      req_b_data          = '0;

      case (state_q)
         ST_SYNC: begin
            if (!fv) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (fv_rise) state_d = capture_enable ? ST_CAPTURE : ST_SKIP;
         end
         ST_SKIP: begin
            if (fv_fall) state_d = ST_IDLE;
         end
         ST_CAPTURE: begin
            if (accept) begin
               if (disc) begin
                  req_a_vld  = 1'b1;
                  req_a_addr = {write_bank_q, idx_q};
                  req_a_data = word_q;
               end
               idx_d = pix_idx;
               if (lane == 2'd3) begin
                  req_b_vld  = 1'b1;
                  req_b_addr = {write_bank_q, pix_idx};
                  req_b_data = merged;
                  word_d     = 32'd0;
                  mask_d     = 4'd0;
               end else begin
                  word_d = merged;
                  mask_d = base_mask | (4'd1 << lane);
               end
               if (pix_cnt_q != 18'h3FFFF) pix_cnt_d = pix_cnt_q + 18'd1;
            end
            if (fv_fall) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (mask_q != 4'd0) begin
               req_a_vld  = 1'b1;
               req_a_addr = {write_bank_q, idx_q};
               req_a_data = word_q;
            end
            word_d  = 32'd0;
            mask_d  = 4'd0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            frame_pixel_count_d = pix_cnt_q;
            frame_error_d       = (pix_cnt_q != PIXELS_C);
            pix_cnt_d           = 18'd0;
            if (!read_lock) begin
               read_bank_d   = !read_bank_q;
               write_bank_d  = !write_bank_q;
               frame_ready_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_SYNC;
      endcase

      // One write port: a held skid word goes first, and at most one new request can queue behind it.
      if (skid_vld_q) begin
         wr_en_d    = 1'b1;
         wr_addr_d  = skid_addr_q;
         wr_data_d  = skid_data_q;
         skid_vld_d = 1'b0;
         if (req_a_vld) begin
            skid_vld_d  = 1'b1;
            skid_addr_d = req_a_addr;
            skid_data_d = req_a_data;
         end else if (req_b_vld) begin
            skid_vld_d  = 1'b1;
            skid_addr_d = req_b_addr;
            skid_data_d = req_b_data;
         end
      end else if (req_a_vld) begin
         wr_en_d   = 1'b1;
         wr_addr_d = req_a_addr;
         wr_data_d = req_a_data;
         if (req_b_vld) begin
            skid_vld_d  = 1'b1;
            skid_addr_d = req_b_addr;
            skid_data_d = req_b_data;
         end
      end else if (req_b_vld) begin
         wr_en_d   = 1'b1;
         wr_addr_d = req_b_addr;
         wr_data_d = req_b_data;
      end

      busy_d = (state_d == ST_CAPTURE) || (state_d == ST_FLUSH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= ST_SYNC;
         fv_prev_q           <= 1'b0;
         word_q              <= 32'd0;
         idx_q               <= '0;
         mask_q              <= 4'd0;
         pix_cnt_q           <= 18'd0;
         wr_en_q             <= 1'b0;
         wr_addr_q           <= '0;
         wr_data_q           <= 32'd0;
         skid_vld_q          <= 1'b0;
         skid_addr_q         <= '0;
         skid_data_q         <= 32'd0;
         read_bank_q         <= 1'b0;
         write_bank_q        <= 1'b1;
         frame_ready_q       <= 1'b0;
         frame_pixel_count_q <= 18'd0;
         frame_error_q       <= 1'b0;
         busy_q              <= 1'b0;
      end else begin
         state_q             <= state_d;
         fv_prev_q           <= fv_prev_d;
         word_q              <= word_d;
         idx_q               <= idx_d;
         mask_q              <= mask_d;
         pix_cnt_q           <= pix_cnt_d;
         wr_en_q             <= wr_en_d;
         wr_addr_q           <= wr_addr_d;
         wr_data_q           <= wr_data_d;
         skid_vld_q          <= skid_vld_d;
         skid_addr_q         <= skid_addr_d;
         skid_data_q         <= skid_data_d;
         read_bank_q         <= read_bank_d;
         write_bank_q        <= write_bank_d;
         frame_ready_q       <= frame_ready_d;
         frame_pixel_count_q <= frame_pixel_count_d;
         frame_error_q       <= frame_error_d;
         busy_q              <= busy_d;
      end
   end

   assign mem_wr_en         = wr_en_q;
   assign mem_wr_addr       = wr_addr_q;
   assign mem_wr_data       = wr_data_q;
   assign mem_rd_addr       = {read_bank_q, rd_addr};
   assign read_bank         = read_bank_q;
   assign frame_ready       = frame_ready_q;
   assign frame_pixel_count = frame_pixel_count_q;
   assign frame_error       = frame_error_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_rgb_frame_packer.sv
// Bench for rgb_frame_packer: frame table with fixed expectations, corner sequences, random frames vs a word-grouping model.
module tb_rgb_frame_packer;
   localparam int PIX = 1024;
   localparam int AW  = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    pixel_data;
   logic [17:0]   pixel_address;
   logic          pixel_wr_en;
   logic          fv;
   logic          capture_enable;
   logic          read_lock;
   logic [AW-1:0] rd_addr;
   logic          mem_wr_en;
   logic [AW:0]   mem_wr_addr;
   logic [31:0]   mem_wr_data;
   logic [AW:0]   mem_rd_addr;
   logic          read_bank;
   logic          frame_ready;
   logic [17:0]   frame_pixel_count;
   logic          frame_error;
   logic          busy;

   rgb_frame_packer #(.PIXELS(PIX), .WORD_AW(AW)) dut (
      .clk(clk), .reset(reset), .pixel_data(pixel_data), .pixel_address(pixel_address),
      .pixel_wr_en(pixel_wr_en), .fv(fv), .capture_enable(capture_enable), .read_lock(read_lock),
      .rd_addr(rd_addr), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_addr(mem_rd_addr), .read_bank(read_bank), .frame_ready(frame_ready),
      .frame_pixel_count(frame_pixel_count), .frame_error(frame_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [AW:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   int          ready_total = 0;
   int          pa[$];
   logic [7:0]  pd[$];
   bit          m_read, m_write, m_err;
   int          m_count, m_ready;
   int          last_drive;

   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         wa.push_back(mem_wr_addr);
         wd.push_back(mem_wr_data);
         wc.push_back(cyc);
      end
      if (frame_ready === 1'b1) ready_total++;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_read  = 1'b0;
      m_write = 1'b1;
      m_count = 0;
      m_err   = 1'b0;
   endtask

   // Expected writes: pixels grouped into words; a word closes on lane 3, on a word-index change, or at frame end.
   task automatic run_frame(input bit cap, input bit lock, input bit fall_last, input bit gaps);
      logic [AW:0] ea[$];
      logic [31:0] ed[$];
      logic [31:0] cw;
      bit          has;
      int          cur, w, l;
      wa.delete(); wd.delete(); wc.delete();
      capture_enable = cap;
      read_lock      = lock;
      rd_addr        = AW'($urandom);
      pixel_wr_en    = 1'b0;
      fv             = 1'b0;
      step(3);
      fv = 1'b1;
      step(1);
      foreach (pa[i]) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            pixel_wr_en = 1'b0;
            step(1);
         end
         pixel_wr_en   = 1'b1;
         pixel_address = 18'(pa[i]);
         pixel_data    = pd[i];
         if (fall_last && i == pa.size() - 1) fv = 1'b0;
         last_drive = cyc;
         step(1);
      end
      pixel_wr_en = 1'b0;
      fv          = 1'b0;
      step(8);

      if (cap) begin
         has = 1'b0; cw = 32'd0; cur = 0;
         foreach (pa[i]) begin
            w = pa[i] / 4;
            l = pa[i] % 4;
            if (has && w != cur) begin
               ea.push_back({m_write, AW'(cur)}); ed.push_back(cw);
               cw = 32'd0; has = 1'b0;
            end
            cw[8*l +: 8] = pd[i];
            cur = w;
            has = 1'b1;
            if (l == 3) begin
               ea.push_back({m_write, AW'(cur)}); ed.push_back(cw);
               cw = 32'd0; has = 1'b0;
            end
         end
         if (has) begin
            ea.push_back({m_write, AW'(cur)}); ed.push_back(cw);
         end
         m_count = (pa.size() > 262143) ? 262143 : pa.size();
         m_err   = (m_count != PIX);
         if (!lock) begin
            m_read  = !m_read;
            m_write = !m_write;
            m_ready++;
         end
      end
      chk("wr_count", wa.size(), ea.size());
      for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
         chk("wr_addr", wa[i], ea[i]);
         chk("wr_data", wd[i], ed[i]);
      end
      chk("pixel_count", frame_pixel_count, m_count);
      chk("frame_error", frame_error, m_err);
      chk("read_bank", read_bank, m_read);
      chk("ready_pulses", ready_total, m_ready);
      chk("busy_idle", busy, 0);
      chk("rd_addr_map", mem_rd_addr, {m_read, rd_addr});
   endtask

   task automatic seq_frame(input int start, input int n);
      pa.delete(); pd.delete();
      for (int k = 0; k < n; k++) begin
         pa.push_back(start + k);
         pd.push_back(8'(start + k));
      end
   endtask

   typedef struct {
      bit          cap;
      bit          lock;
      bit          fall;
      int          start;
      int          npix;
      int          exp_count;
      bit          exp_err;
      bit          exp_bank;
      int          exp_ready;
      int          exp_nwr;
      logic [16:0] a0;
      logic [31:0] d0;
      logic [16:0] al;
      logic [31:0] dl;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int r0, n, a;
      tbl[0] = '{1, 0, 0, 0, 1024, 1024, 0, 1, 1, 256, 17'h10000, 32'h03020100, 17'h100FF, 32'hFFFEFDFC};
      tbl[1] = '{1, 0, 1, 0, 6,    6,    1, 0, 1, 2,   17'h00000, 32'h03020100, 17'h00001, 32'h00000504};
      tbl[2] = '{1, 1, 0, 0, 8,    8,    1, 0, 0, 2,   17'h10000, 32'h03020100, 17'h10001, 32'h07060504};
      tbl[3] = '{1, 1, 0, 4, 4,    4,    1, 0, 0, 1,   17'h10001, 32'h07060504, 17'h10001, 32'h07060504};
      tbl[4] = '{1, 0, 0, 0, 1024, 1024, 0, 1, 1, 256, 17'h10000, 32'h03020100, 17'h100FF, 32'hFFFEFDFC};
      tbl[5] = '{0, 0, 0, 0, 5,    1024, 0, 1, 0, 0,   17'h00000, 32'h0,        17'h00000, 32'h0};
      tbl[6] = '{1, 0, 0, 2, 3,    3,    1, 0, 1, 2,   17'h00000, 32'h03020000, 17'h00001, 32'h00000004};

      reset = 1'b1; pixel_data = 8'd0; pixel_address = 18'd0; pixel_wr_en = 1'b0;
      fv = 1'b0; capture_enable = 1'b0; read_lock = 1'b0; rd_addr = 16'h1234;
      m_ready = 0;
      model_reset();
      step(3);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_wr_addr", mem_wr_addr, 0);
      chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_read_bank", read_bank, 0);
      chk("rst_frame_ready", frame_ready, 0);
      chk("rst_pixel_count", frame_pixel_count, 0);
      chk("rst_frame_error", frame_error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rd_addr", mem_rd_addr, 17'h01234);
      reset = 1'b0;
      step(2);

      foreach (tbl[t]) begin
         seq_frame(tbl[t].start, tbl[t].npix);
         r0 = ready_total;
         run_frame(tbl[t].cap, tbl[t].lock, tbl[t].fall, 1'b0);
         chk($sformatf("tbl%0d_count", t), frame_pixel_count, tbl[t].exp_count);
         chk($sformatf("tbl%0d_err", t), frame_error, tbl[t].exp_err);
         chk($sformatf("tbl%0d_bank", t), read_bank, tbl[t].exp_bank);
         chk($sformatf("tbl%0d_ready", t), ready_total - r0, tbl[t].exp_ready);
         chk($sformatf("tbl%0d_nwr", t), wa.size(), tbl[t].exp_nwr);
         if (tbl[t].exp_nwr > 0 && wa.size() > 0) begin
            chk($sformatf("tbl%0d_a0", t), wa[0], tbl[t].a0);
            chk($sformatf("tbl%0d_d0", t), wd[0], tbl[t].d0);
            chk($sformatf("tbl%0d_alast", t), wa[wa.size()-1], tbl[t].al);
            chk($sformatf("tbl%0d_dlast", t), wd[wd.size()-1], tbl[t].dl);
         end
      end

      // Discontinuity into lane 3: two writes on back-to-back cycles.
      pa = '{0, 1, 7}; pd = '{8'hA0, 8'hA1, 8'hA7};
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      if (wa.size() == 2) begin
         chk("jump_w0_data", wd[0], 32'h0000A1A0);
         chk("jump_w1_data", wd[1], 32'hA7000000);
         chk("jump_w1_word", wa[1][AW-1:0], 1);
         chk("jump_w0_latency", wc[0] - last_drive, 1);
         chk("jump_w1_back2back", wc[1] - wc[0], 1);
      end else chk("jump_nwr", wa.size(), 2);

      // Chained lane-3 jumps keep the skid busy for several cycles.
      pa = '{0, 1, 7, 11, 15}; pd = '{8'h10, 8'h11, 8'h17, 8'h1B, 8'h1F};
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      if (wa.size() == 4) chk("chain_back2back", wc[3] - wc[0], 3);
      else chk("chain_nwr", wa.size(), 4);

      // Lane-3 closing pixel: write one cycle later.
      seq_frame(8, 4);
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);
      if (wa.size() == 1) chk("lane3_latency", wc[0] - last_drive, 1);
      else chk("lane3_nwr", wa.size(), 1);

      // Reset in the middle of a frame: nothing is written until fv falls and rises again.
      capture_enable = 1'b1; read_lock = 1'b0; fv = 1'b0;
      step(3);
      fv = 1'b1;
      step(1);
      for (int k = 0; k < 3; k++) begin
         pixel_wr_en = 1'b1; pixel_address = 18'(k); pixel_data = 8'(k);
         step(1);
      end
      wa.delete(); wd.delete(); wc.delete();
      reset = 1'b1; pixel_address = 18'd3;
      step(2);
      reset = 1'b0;
      model_reset();
      for (int k = 4; k < 12; k++) begin
         pixel_wr_en = 1'b1; pixel_address = 18'(k); pixel_data = 8'(k);
         step(1);
      end
      pixel_wr_en = 1'b0;
      step(2);
      chk("midrst_no_writes", wa.size(), 0);
      chk("midrst_read_bank", read_bank, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", frame_pixel_count, 0);
      seq_frame(0, 8);
      run_frame(1'b1, 1'b0, 1'b0, 1'b0);

      for (int f = 0; f < 30; f++) begin
         pa.delete(); pd.delete();
         n = $urandom_range(1, 24);
         a = $urandom_range(0, 60);
         for (int k = 0; k < n; k++) begin
            pa.push_back(a);
            pd.push_back(8'($urandom));
            a = ($urandom_range(0, 3) != 0) ? a + 1 : int'($urandom_range(0, 100));
         end
         run_frame($urandom_range(0, 6) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
